// File: rtl/core_pipeline_pkg.sv
// Shared fetch->decode boundary types: address/instruction widths and the
// {address, instruction} entry carried from fetch to decode.
package core_pipeline_pkg;

  localparam int addressSize     = 64;
  localparam int instructionSize = 32;

  typedef struct packed {
    logic [addressSize-1:0]     address;
    logic [instructionSize-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch instruction queue: one synchronous write port,
// one asynchronous read port, contents cleared by the asynchronous reset.
module fetch_queue_storage
  import core_pipeline_pkg::*;
#(
  parameter int queueDepth   = 4,
  parameter int queuePtrBits = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    write_en,
  input  logic [queuePtrBits-1:0] write_ptr,
  input  fetch_entry_t            write_data,
  input  logic [queuePtrBits-1:0] read_ptr,
  output fetch_entry_t            read_data
);

  fetch_entry_t mem [queueDepth];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < queueDepth; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[write_ptr] <= write_data;
    end
  end

  assign read_data = mem[read_ptr];

endmodule

// File: rtl/fetch_instruction_queue.sv
// Fetch->decode instruction queue with valid/ready handoff, early fetch stall,
// sticky overflow and flush. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_instruction_queue
  import core_pipeline_pkg::*;
#(
  parameter int queueDepth   = 4,
  parameter int queuePtrBits = 2,
  parameter int stallSlack   = 2
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       flushPipeline_i,
  input  logic                       enable_i,
  input  logic [addressSize-1:0]     instructionAddress_i,
  input  logic [instructionSize-1:0] instruction_i,
  input  logic                       decodeReady_i,
  output logic                       enable_o,
  output logic [addressSize-1:0]     instructionAddress_o,
  output logic [instructionSize-1:0] instruction_o,
  output logic                       stallFetch_o,
  output logic                       overflow_o
);

  localparam logic [queuePtrBits:0]   FULL_COUNT  = (queuePtrBits+1)'(queueDepth);
  localparam logic [queuePtrBits:0]   STALL_COUNT = (queuePtrBits+1)'(queueDepth - stallSlack);
  localparam logic [queuePtrBits:0]   CNT_ONE     = (queuePtrBits+1)'(1);
  localparam logic [queuePtrBits-1:0] PTR_ONE     = queuePtrBits'(1);

  logic [queuePtrBits-1:0] head_ptr;
  logic [queuePtrBits-1:0] tail_ptr;
  logic [queuePtrBits:0]   count;
  logic                    overflow;

  fetch_entry_t in_entry;
  fetch_entry_t head_entry;
  fetch_entry_t out_entry;

  logic empty;
  logic full;
  logic queue_valid;
  logic bypass;
  logic pop;
  logic queue_pop;
  logic push;
  logic dropped;

  assign in_entry.address     = instructionAddress_i;
  assign in_entry.instruction = instruction_i;

  assign empty       = (count == '0);
  assign full        = (count == FULL_COUNT);
  assign queue_valid = ~empty & ~flushPipeline_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: hand the incoming entry straight to decode this cycle.
  assign bypass    = empty & enable_i & ~flushPipeline_i;
  assign enable_o  = queue_valid | bypass;
  assign out_entry = bypass ? in_entry : head_entry;
`else
  assign bypass    = 1'b0;
  assign enable_o  = queue_valid;
  assign out_entry = head_entry;
`endif

  assign pop       = enable_o & decodeReady_i;
  // A bypassed hand-off never occupied a slot, so it must not move the head.
  assign queue_pop = pop & ~bypass;
  assign push      = enable_i & ~flushPipeline_i & (~full | queue_pop)
                   & ~(bypass & decodeReady_i);
  assign dropped   = enable_i & ~flushPipeline_i & full & ~queue_pop;

  assign instructionAddress_o = enable_o ? out_entry.address     : '0;
  assign instruction_o        = enable_o ? out_entry.instruction : '0;
  assign stallFetch_o         = (count >= STALL_COUNT);
  assign overflow_o           = overflow;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flushPipeline_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)      tail_ptr <= tail_ptr + PTR_ONE;
      if (queue_pop) head_ptr <= head_ptr + PTR_ONE;
      case ({push, queue_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (dropped) overflow <= 1'b1;
    end
  end

  fetch_queue_storage #(
    .queueDepth   (queueDepth),
    .queuePtrBits (queuePtrBits)
  ) u_storage (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .write_en   (push),
    .write_ptr  (tail_ptr),
    .write_data (in_entry),
    .read_ptr   (head_ptr),
    .read_data  (head_entry)
  );

endmodule
